// File: rtl/key_press_detect.sv
// Debounces an active-low push-button and turns it into a clean level plus
// registered single-cycle short-press, long-press and auto-repeat pulses.
module key_press_detect #(
   parameter int unsigned DEBOUNCE   = 1_000_000,
   parameter int unsigned LONG_PRESS = 50_000_000,
   parameter int unsigned REPEAT     = 10_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic key_level,
   output logic key_short,
   output logic key_long,
   output logic key_repeat
);

   localparam int unsigned DW = $clog2(DEBOUNCE);
   localparam int unsigned HW = $clog2(LONG_PRESS);
   localparam int unsigned RW = $clog2(REPEAT);

   localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE - 1);
   localparam logic [HW-1:0] HLAST = HW'(LONG_PRESS - 1);
   localparam logic [RW-1:0] RLAST = RW'(REPEAT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StPressDb,
      StHeld,
      StLongHeld,
      StReleaseDb
   } state_e;

   state_e        state_q, state_d;
   logic          sync1_q, ks_q;
   logic [DW-1:0] dcnt_q, dcnt_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic          from_long_q, from_long_d;
   logic          level_d, short_d, long_d, repeat_d;

   // Two-flop synchronizer; idles high so reset looks like a released key.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b1;
         ks_q    <= 1'b1;
      end else begin
         sync1_q <= key_n;
         ks_q    <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         dcnt_q      <= '0;
         hcnt_q      <= '0;
         rcnt_q      <= '0;
         from_long_q <= 1'b0;
         key_level   <= 1'b0;
         key_short   <= 1'b0;
         key_long    <= 1'b0;
         key_repeat  <= 1'b0;
      end else begin
         state_q     <= state_d;
         dcnt_q      <= dcnt_d;
         hcnt_q      <= hcnt_d;
         rcnt_q      <= rcnt_d;
         from_long_q <= from_long_d;
         key_level   <= level_d;
         key_short   <= short_d;
         key_long    <= long_d;
         key_repeat  <= repeat_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      dcnt_d      = dcnt_q;
      hcnt_d      = hcnt_q;
      rcnt_d      = rcnt_q;
      from_long_d = from_long_q;
      case (state_q)
         StIdle: begin
            if (!ks_q) begin
               state_d = StPressDb;
               dcnt_d  = '0;
            end
         end
         StPressDb: begin
            if (ks_q) begin
               state_d = StIdle;
            end else if (dcnt_q == DLAST) begin
               state_d = StHeld;
               hcnt_d  = '0;
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         StHeld: begin
            // Release takes priority over a long-press completing this cycle.
            if (ks_q) begin
               state_d     = StReleaseDb;
               dcnt_d      = '0;
               from_long_d = 1'b0;
            end else if (hcnt_q == HLAST) begin
               state_d = StLongHeld;
               rcnt_d  = '0;
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         StLongHeld: begin
            if (ks_q) begin
               state_d     = StReleaseDb;
               dcnt_d      = '0;
               from_long_d = 1'b1;
            end else if (rcnt_q == RLAST) begin
               rcnt_d = '0;
            end else begin
               rcnt_d = rcnt_q + 1'b1;
            end
         end
         StReleaseDb: begin
            // hcnt/rcnt stay frozen so a release bounce resumes where it left off.
            if (!ks_q) begin
               state_d = from_long_q ? StLongHeld : StHeld;
            end else if (dcnt_q == DLAST) begin
               state_d = StIdle;
            end else begin
               dcnt_d = dcnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      level_d  = key_level;
      short_d  = 1'b0;
      long_d   = 1'b0;
      repeat_d = 1'b0;
      case (state_q)
         StPressDb:   if (!ks_q && (dcnt_q == DLAST)) level_d = 1'b1;
         StHeld:      if (!ks_q && (hcnt_q == HLAST)) long_d = 1'b1;
         StLongHeld:  if (!ks_q && (rcnt_q == RLAST)) repeat_d = 1'b1;
         StReleaseDb: begin
            if (ks_q && (dcnt_q == DLAST)) begin
               level_d = 1'b0;
               short_d = !from_long_q;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_key_press_detect.sv
// Bench for key_press_detect: directed scenarios with literal event timings plus
// random key activity, all compared each cycle against a run-length model.
module tb_key_press_detect;

   localparam int D  = 4;
   localparam int LP = 20;
   localparam int R  = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic key_n = 1'b1;
   logic key_level, key_short, key_long, key_repeat;

   int checks   = 0;
   int failures = 0;

   // Model: accepted level, run length of disagreeing samples, pressed cycles counted.
   bit m_s1, m_ks, m_level, m_short, m_long, m_rep;
   int m_run, m_held;

   int cyc, rise_at, fall_at, short_at, long_at, n_short, n_long, n_rep;
   int rep_at[$];

   key_press_detect #(
      .DEBOUNCE  (D),
      .LONG_PRESS(LP),
      .REPEAT    (R)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_n     (key_n),
      .key_level (key_level),
      .key_short (key_short),
      .key_long  (key_long),
      .key_repeat(key_repeat)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_s1 = 1'b1; m_ks = 1'b1; m_level = 1'b0;
      m_short = 1'b0; m_long = 1'b0; m_rep = 1'b0;
      m_run = 0; m_held = 0;
   endtask

   task automatic model_edge(input bit kn);
      bit ks;
      ks = m_ks;
      m_short = 1'b0; m_long = 1'b0; m_rep = 1'b0;
      if (!m_level) begin
         if (!ks) begin
            m_run++;
            if (m_run == D + 1) begin
               m_level = 1'b1; m_run = 0; m_held = 0;
            end
         end else begin
            m_run = 0;
         end
      end else if (ks) begin
         m_run++;
         if (m_run == D + 1) begin
            m_level = 1'b0;
            m_short = (m_held < LP);
            m_run   = 0;
         end
      end else if (m_run > 0) begin
         m_run = 0;
      end else begin
         m_held++;
         if (m_held == LP) m_long = 1'b1;
         else if (m_held > LP && ((m_held - LP) % R) == 0) m_rep = 1'b1;
      end
      m_ks = m_s1;
      m_s1 = kn;
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic begin_scn();
      cyc = 0; rise_at = -1; fall_at = -1; short_at = -1; long_at = -1;
      n_short = 0; n_long = 0; n_rep = 0;
      rep_at.delete();
   endtask

   task automatic step(input bit kn);
      bit pl;
      key_n = kn;
      pl = m_level;
      @(posedge clk);
      if (rst_n) model_edge(kn);
      else model_reset();
      cyc++;
      @(negedge clk);
      checks++;
      if ({key_level, key_short, key_long, key_repeat} !==
          {m_level, m_short, m_long, m_rep}) begin
         failures++;
         $display("FAIL outputs t=%0t got(lvl,sht,lng,rep)=%b%b%b%b expected=%b%b%b%b",
                  $time, key_level, key_short, key_long, key_repeat,
                  m_level, m_short, m_long, m_rep);
      end
      if (m_level && !pl && rise_at < 0) rise_at = cyc;
      if (!m_level && pl && fall_at < 0) fall_at = cyc;
      if (m_short) begin n_short++; if (short_at < 0) short_at = cyc; end
      if (m_long) begin n_long++; if (long_at < 0) long_at = cyc; end
      if (m_rep) begin n_rep++; rep_at.push_back(cyc); end
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b1);
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      repeat (3) step(1'b1);
      check_int("reset_outputs", int'({key_level, key_short, key_long, key_repeat}), 0);
      rst_n = 1'b1;
      idle(3);

      // Clean short press
      begin_scn();
      repeat (12) step(1'b0);
      idle(15);
      check_int("short_rise", rise_at, 7);
      check_int("short_fall", fall_at, 19);
      check_int("short_pulse_at", short_at, 19);
      check_int("short_count", n_short, 1);
      check_int("short_no_long", n_long + n_rep, 0);

      // Bounce rejected
      begin_scn();
      step(1'b0); step(1'b0); step(1'b1); step(1'b0); step(1'b0);
      idle(20);
      check_int("bounce_no_rise", rise_at, -1);
      check_int("bounce_no_pulse", n_short + n_long + n_rep, 0);

      // Long press with repeat
      begin_scn();
      repeat (40) step(1'b0);
      idle(15);
      check_int("long_rise", rise_at, 7);
      check_int("long_at", long_at, 27);
      check_int("long_rep0", (rep_at.size() > 0) ? rep_at[0] : -1, 32);
      check_int("long_rep1", (rep_at.size() > 1) ? rep_at[1] : -1, 37);
      check_int("long_no_short", n_short, 0);
      check_int("long_fall", fall_at, 47);

      // Release bounce resumes hold counting
      begin_scn();
      repeat (17) step(1'b0);
      step(1'b1); step(1'b1);
      repeat (30) step(1'b0);
      idle(15);
      check_int("rb_rise", rise_at, 7);
      check_int("rb_long_at", long_at, 30);
      check_int("rb_no_short", n_short, 0);
      check_int("rb_fall", fall_at, 56);

      // Release seen in the cycle the hold would complete
      begin_scn();
      repeat (24) step(1'b0);
      idle(15);
      check_int("sim_no_long", n_long, 0);
      check_int("sim_short_at", short_at, 31);
      check_int("sim_fall", fall_at, 31);

      // Reset during long hold, key still pressed afterwards
      begin_scn();
      repeat (30) step(1'b0);
      check_int("rst_pre_long", long_at, 27);
      rst_n = 1'b0;
      #1;
      check_int("rst_async_outputs", int'({key_level, key_short, key_long, key_repeat}), 0);
      model_reset();
      repeat (3) step(1'b0);
      rst_n = 1'b1;
      begin_scn();
      repeat (20) step(1'b0);
      idle(15);
      check_int("rst_rerise", rise_at, 7);

      // Random bursts
      for (int b = 0; b < 80; b++) begin
         bit kn;
         int len;
         kn  = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 45))
                                           : int'($urandom_range(1, 7));
         repeat (len) step(kn);
      end
      idle(15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
